// File: rtl/ex2_sw_debounce_if.sv
// Switch-conditioning bus between the raw board switches and the debouncer.
//   sw_raw      : raw, asynchronous switch levels (driven by the board side)
//   sw_stable   : debounced switch levels
//   sw_rise     : one-cycle pulse per bit on an accepted 0->1
//   sw_fall     : one-cycle pulse per bit on an accepted 1->0
//   sw_changed  : one-cycle pulse when any stable bit changes
// master = board/consumer side, slave = debouncer.
interface ex2_sw_debounce_if #(
    parameter int unsigned WIDTH = 9
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/ex2_sw_debounce.sv
// Slide-switch conditioner ahead of the 8-to-3 priority encoder.
// Each bit is synchronised by two flops and then debounced by its own
// counter: a synced bit must differ from its stable level for DB_CYCLES
// consecutive clocks before the new level is accepted. Bits [7:0] feed X,
// bit [8] feeds en. All outputs are registered; nothing from sw_raw reaches
// an output combinationally.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   sw     : ex2_sw_debounce_if.slave (sw_raw in; sw_stable, sw_rise,
//            sw_fall, sw_changed out)
// DB_CYCLES must be >= 2. The interface WIDTH must equal WIDTH here.
module ex2_sw_debounce #(
    parameter int unsigned      WIDTH     = 9,
    parameter int unsigned      DB_CYCLES = 20000,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ex2_sw_debounce_if.slave     sw
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

    // Synchroniser stages
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Debounce state
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] stable_q,  stable_nxt;
    logic [WIDTH-1:0] rise_q,    rise_nxt;
    logic [WIDTH-1:0] fall_q,    fall_nxt;
    logic             changed_q, changed_nxt;

    // Two-flop synchroniser, no logic between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= sw.sw_raw;
            s2_q <= s1_q;
        end
    end

    // Per-bit qualification; terminal count accepts the new level and
    // returns the counter to 0, so it can never wrap.
    always_comb begin
        stable_nxt  = stable_q;
        rise_nxt    = '0;
        fall_nxt    = '0;
        changed_nxt = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (s2_q[i] == stable_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                cnt_nxt[i]    = '0;
                stable_nxt[i] = s2_q[i];
                rise_nxt[i]   = s2_q[i];
                fall_nxt[i]   = ~s2_q[i];
            end else begin
                cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_nxt = |(rise_nxt | fall_nxt);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q  <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
            stable_q  <= stable_nxt;
            rise_q    <= rise_nxt;
            fall_q    <= fall_nxt;
            changed_q <= changed_nxt;
        end
    end

    assign sw.sw_stable  = stable_q;
    assign sw.sw_rise    = rise_q;
    assign sw.sw_fall    = fall_q;
    assign sw.sw_changed = changed_q;

endmodule
